// File: rtl/reg_bank.sv
// Multi-entry register bank with per-entry valid flags.
// Supports one load/inc/clear per cycle and two write-first registered read ports.
module reg_bank_entry #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clear_n,
    input  logic         sel,
    input  logic [1:0]   op,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] nxt,
    output logic         nxt_vld,
    output logic         wrap
);
    logic [W-1:0] q;
    logic         v;

    // The next-state value is exported so that read ports see this edge's write
    always_comb begin
        nxt     = q;
        nxt_vld = v;
        wrap    = 1'b0;
        if (sel) begin
            case (op)
                2'b01: begin
                    nxt     = wdata;
                    nxt_vld = 1'b1;
                end
                2'b10: begin
                    nxt     = q + W'(1);
                    nxt_vld = 1'b1;
                    wrap    = &q;
                end
                2'b11: begin
                    nxt     = '0;
                    nxt_vld = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            q <= '0;
            v <= 1'b0;
        end else begin
            q <= nxt;
            v <= nxt_vld;
        end
    end
endmodule

module reg_bank #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          clear_n,
    input  logic [1:0]    op,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic [W-1:0]  rdata_a,
    output logic [W-1:0]  rdata_b,
    output logic          rvalid_a,
    output logic          rvalid_b,
    output logic          carry
);
    localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

    logic [DEPTH-1:0][W-1:0] nxt;
    logic [DEPTH-1:0]        nxt_vld;
    logic [DEPTH-1:0]        wrap;
    logic                    ra_ok, rb_ok;

    // An out-of-range waddr matches no entry, so it naturally acts as a NOP
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        localparam logic [AW-1:0] IDX = AW'(i);
        reg_bank_entry #(.W(W)) u_ent (
            .clk     (clk),
            .clear_n (clear_n),
            .sel     (waddr == IDX),
            .op      (op),
            .wdata   (wdata),
            .nxt     (nxt[i]),
            .nxt_vld (nxt_vld[i]),
            .wrap    (wrap[i])
        );
    end

    assign ra_ok = {1'b0, raddr_a} < DEPTH_W;
    assign rb_ok = {1'b0, raddr_b} < DEPTH_W;

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            rdata_a  <= '0;
            rdata_b  <= '0;
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
            carry    <= 1'b0;
        end else begin
            rdata_a  <= ra_ok ? nxt[raddr_a] : '0;
            rdata_b  <= rb_ok ? nxt[raddr_b] : '0;
            rvalid_a <= ra_ok & nxt_vld[raddr_a];
            rvalid_b <= rb_ok & nxt_vld[raddr_b];
            carry    <= |wrap;
        end
    end
endmodule

// File: tb/tb_reg_bank.sv
// Directed plus randomized checks of reg_bank (W=8, DEPTH=6) against an array model.
module tb_reg_bank;
    localparam int W = 8, DEPTH = 6, AW = 3;

    logic          clk = 1'b0;
    logic          clear_n;
    logic [1:0]    op;
    logic [AW-1:0] waddr, raddr_a, raddr_b;
    logic [W-1:0]  wdata, rdata_a, rdata_b;
    logic          rvalid_a, rvalid_b, carry;

    int tests = 0, fails = 0;
    int m_val [DEPTH];
    bit m_vld [DEPTH];

    reg_bank #(.W(W), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .clear_n(clear_n), .op(op), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
        .rvalid_a(rvalid_a), .rvalid_b(rvalid_b), .carry(carry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle, advance the model by the spec rules, compare all outputs
    task automatic step(input string tag, input bit rst_n, input int o, input int wa,
                        input int wd, input int ra, input int rb);
        int e_carry, e_ra, e_rb;
        bit e_va, e_vb;
        clear_n = rst_n;
        op      = o[1:0];
        waddr   = wa[AW-1:0];
        wdata   = wd[W-1:0];
        raddr_a = ra[AW-1:0];
        raddr_b = rb[AW-1:0];
        @(posedge clk);
        #1;
        e_carry = 0;
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_val[i] = 0;
                m_vld[i] = 0;
            end
        end else if (wa < DEPTH) begin
            case (o)
                1: begin m_val[wa] = wd % 256; m_vld[wa] = 1; end
                2: begin
                    e_carry   = (m_val[wa] == 255) ? 1 : 0;
                    m_val[wa] = (m_val[wa] + 1) % 256;
                    m_vld[wa] = 1;
                end
                3: begin m_val[wa] = 0; m_vld[wa] = 0; end
                default: ;
            endcase
        end
        e_ra = (rst_n && ra < DEPTH) ? m_val[ra] : 0;
        e_va = (rst_n && ra < DEPTH) ? m_vld[ra] : 0;
        e_rb = (rst_n && rb < DEPTH) ? m_val[rb] : 0;
        e_vb = (rst_n && rb < DEPTH) ? m_vld[rb] : 0;
        chk({tag, ".rdata_a"}, 32'(rdata_a), e_ra);
        chk({tag, ".rvalid_a"}, 32'(rvalid_a), 32'(e_va));
        chk({tag, ".rdata_b"}, 32'(rdata_b), e_rb);
        chk({tag, ".rvalid_b"}, 32'(rvalid_b), 32'(e_vb));
        chk({tag, ".carry"}, 32'(carry), e_carry);
    endtask

    initial begin
        // Reset with a LOAD pending: reset must win
        step("rst0", 0, 1, 3, 8'hAA, 3, 3);
        step("rst1", 0, 1, 3, 8'hAA, 3, 0);
        for (int i = 0; i < DEPTH; i++) step("rdall", 1, 0, 0, 0, i, DEPTH - 1 - i);

        step("load_wf", 1, 1, 2, 8'h5C, 2, 5);

        step("ld1", 1, 1, 1, 8'hFE, 1, 2);
        step("inc_ff", 1, 2, 1, 0, 1, 1);
        step("inc_wrap", 1, 2, 1, 0, 1, 2);
        step("post_wrap", 1, 0, 0, 0, 1, 1);

        step("ld4", 1, 1, 4, 8'h33, 4, 4);
        step("clr4", 1, 3, 4, 0, 4, 2);
        step("inc4", 1, 2, 4, 0, 4, 4);

        step("oor_ld", 1, 1, 7, 8'h77, 6, 2);
        for (int i = 0; i < DEPTH; i++) step("oor_rd", 1, 0, 0, 0, i, 7);

        step("ld0ff", 1, 1, 0, 8'hFF, 0, 0);
        step("rst_inc", 0, 2, 0, 0, 0, 0);
        step("rst_chk", 1, 0, 0, 0, 0, 1);

        // Random traffic biased toward in-range addresses, with occasional resets
        for (int n = 0; n < 400; n++) begin
            int o, wa, ra, rb;
            bit r;
            r  = ($urandom_range(0, 39) != 0);
            o  = $urandom_range(0, 3);
            wa = ($urandom_range(0, 7) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
            ra = $urandom_range(0, 7);
            rb = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 7);
            // Frequent loads of near-wrap values exercise carry
            step("rand", r, o, wa, ($urandom_range(0, 1) != 0) ? 8'hFF : $urandom_range(0, 255), ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
